exp_share_arbiter: RTL

EXP_SHARE_ARBITER -- requirements
Module: exp_share_arbiter

---
 rtl/exp_share_pkg.sv | 19 +
 rtl/exp_share_fifo.sv | 49 ++++
 rtl/exp_share_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/exp_share_pkg.sv
// Shared types and parameter derivations for the exp-unit sharing arbiter.
package exp_share_pkg;

  localparam int MaxIdWidth = 4;

  typedef struct packed {
    logic                  valid;
    logic [MaxIdWidth-1:0] id;
  } track_entry_t;

  function automatic int calc_fifo_depth(input int latency);
    return latency + 2;
  endfunction

  function automatic int calc_id_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/exp_share_fifo.sv
// Result buffer: registered circular FIFO with an occupancy count output.
module exp_share_fifo #(
  parameter  int Depth  = 5,
  parameter  int EntryW = 34,
  localparam int CntW   = $clog2(Depth + 1),
  localparam int PtrW   = (Depth <= 2) ? 1 : $clog2(Depth)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [EntryW-1:0] push_data_i,
  input  logic              pop_i,
  output logic [EntryW-1:0] head_o,
  output logic [CntW-1:0]   count_o
);

  logic [EntryW-1:0] mem [Depth];
  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_ptr;
  logic [CntW-1:0]   count;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= next_ptr(wr_ptr);
      if (pop_i)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_i, pop_i})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_o  = mem[rd_ptr];
  assign count_o = count;

endmodule

// File: rtl/exp_share_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined exp unit among NumReq
// requesters, with credit-based flow control into an in-order result buffer.
module exp_share_arbiter
  import exp_share_pkg::*;
#(
  parameter  int NumReq    = 4,
  parameter  int DataWidth = 32,
  parameter  int Latency   = 3,
  localparam int FifoDepth = calc_fifo_depth(Latency),
  localparam int IdWidth   = calc_id_width(NumReq)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  input  logic [NumReq*DataWidth-1:0] req_operand_i,
  output logic [DataWidth-1:0]        unit_operand_o,
  input  logic [DataWidth-1:0]        unit_result_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [DataWidth-1:0]        rsp_result_o,
  output logic [IdWidth-1:0]          rsp_id_o
);

  localparam int CntW   = $clog2(FifoDepth + 1);
  localparam int EntryW = IdWidth + DataWidth;

  logic [IdWidth-1:0] rr_ptr;
  logic [IdWidth-1:0] winner;
  logic               found;
  logic               issue;
  logic               credit_ok;
  logic [CntW-1:0]    inflight;
  logic [CntW-1:0]    occupancy;
  track_entry_t       track_p [Latency];
  logic [EntryW-1:0]  head;
  logic               pop;
  logic               unused_id_bits;

  // Two passes give "first valid at or above rr_ptr, wrapping" with constant indices.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int j = 0; j < NumReq; j++) begin
      if (!found && req_valid_i[j] && (j >= int'(rr_ptr))) begin
        found  = 1'b1;
        winner = IdWidth'(j);
      end
    end
    for (int j = 0; j < NumReq; j++) begin
      if (!found && req_valid_i[j] && (j < int'(rr_ptr))) begin
        found  = 1'b1;
        winner = IdWidth'(j);
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < Latency; k++) inflight = inflight + CntW'(track_p[k].valid);
  end

  // Every issued op holds a slot from issue until pop, so a push never finds the FIFO full.
  assign credit_ok = ({1'b0, inflight} + {1'b0, occupancy}) < (CntW + 1)'(FifoDepth);
  assign issue     = !rst_i && found && credit_ok;

  always_comb begin
    req_ready_o    = '0;
    unit_operand_o = '0;
    if (issue) req_ready_o[winner] = 1'b1;
    for (int j = 0; j < NumReq; j++) begin
      if (issue && (winner == IdWidth'(j))) unit_operand_o = req_operand_i[j*DataWidth +: DataWidth];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (winner == IdWidth'(NumReq - 1)) ? '0 : winner + IdWidth'(1);
    end
  end

  // Stage 0 tags the issue cycle; the last stage lines up with unit_result_i.
  always_ff @(posedge clk_i) begin
    track_p[0] <= '{valid: issue, id: MaxIdWidth'(winner)};
    for (int k = 1; k < Latency; k++) track_p[k] <= track_p[k-1];
    if (rst_i) begin
      for (int k = 0; k < Latency; k++) track_p[k].valid <= 1'b0;
    end
  end

  assign unused_id_bits = ^track_p[Latency-1].id;

  exp_share_fifo #(
    .Depth (FifoDepth),
    .EntryW(EntryW)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (track_p[Latency-1].valid),
    .push_data_i({track_p[Latency-1].id[IdWidth-1:0], unit_result_i}),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (occupancy)
  );

  assign rsp_valid_o  = !rst_i && (occupancy != '0);
  assign pop          = rsp_valid_o && rsp_ready_i;
  assign rsp_result_o = head[DataWidth-1:0];
  assign rsp_id_o     = head[EntryW-1 -: IdWidth];

endmodule
